// File: rtl/fpu_issue_ctrl_if.sv
// ============================================================================
// Module      : fpu_issue_ctrl_if
// Description : Instruction-issue / FPU-control bundle between the front end
//               (master) and fpu_issue_ctrl (slave).
//   instr_valid, instr    : instruction presented this cycle (master -> slave)
//   stall                 : combinational hold request (slave -> master)
//   fpu_start/sub/dbl     : datapath launch pulse and its operation qualifiers
//   fwb_en, fwb_addr      : float-register file write port
//   busy_mask             : per-register pending-write scoreboard
//   illegal               : undecodable FR instruction pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpu_issue_ctrl_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        stall;
    logic        fpu_start;
    logic        fpu_sub;
    logic        fpu_dbl;
    logic        fwb_en;
    logic [4:0]  fwb_addr;
    logic [31:0] busy_mask;
    logic        illegal;

    modport master (
        output instr_valid, instr,
        input  stall, fpu_start, fpu_sub, fpu_dbl, fwb_en, fwb_addr,
               busy_mask, illegal
    );

    modport slave (
        input  instr_valid, instr,
        output stall, fpu_start, fpu_sub, fpu_dbl, fwb_en, fwb_addr,
               busy_mask, illegal
    );
endinterface

`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
// ============================================================================
// Module      : fpu_issue_ctrl
// Description : Issue controller for a single-issue FP add/sub unit. Decodes
//               FR add/sub, tracks float-register hazards with a busy
//               scoreboard, sequences execute latency and writeback.
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high
//   bus    : fpu_issue_ctrl_if.slave (instruction in, stall/control out)
// Parameters  : FPU_LAT   (1..15) single-precision execute cycles
//               DBL_EXTRA (0..15) extra execute cycles for double precision
// Options     : FPU_DOUBLE_FMT_EN - enables fmt 0x11 (double) with an
//               even/odd register pair written back over two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_issue_ctrl #(
    parameter int FPU_LAT   = 3,
    parameter int DBL_EXTRA = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    fpu_issue_ctrl_if.slave bus
);

    // Counter must hold the longest load value (double case).
    localparam int c_CNT_W = $clog2(FPU_LAT + DBL_EXTRA + 1);
    localparam logic [c_CNT_W-1:0] c_LOAD_SGL = c_CNT_W'(FPU_LAT - 1);
`ifdef FPU_DOUBLE_FMT_EN
    localparam logic [c_CNT_W-1:0] c_LOAD_DBL = c_CNT_W'(FPU_LAT + DBL_EXTRA - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
`ifdef FPU_DOUBLE_FMT_EN
        ,S_WB2 = 2'd3
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0] w_opcode;
    logic [4:0] w_fmt;
    logic [4:0] w_ft;
    logic [4:0] w_fs;
    logic [4:0] w_fd;
    logic [5:0] w_funct;
    logic       w_is_fr;
    logic       w_is_mem;
    logic       w_funct_ok;
    logic       w_legal;
    logic       w_stall;
    logic       w_accept;
    logic       w_illegal;

    assign w_opcode = bus.instr[31:26];
    assign w_fmt    = bus.instr[25:21];
    assign w_ft     = bus.instr[20:16];
    assign w_fs     = bus.instr[15:11];
    assign w_fd     = bus.instr[10:6];
    assign w_funct  = bus.instr[5:0];

    assign w_is_fr    = bus.instr_valid && (w_opcode == 6'h11);
    assign w_is_mem   = bus.instr_valid && ((w_opcode == 6'h31) || (w_opcode == 6'h39));
    // funct 0x00 = add, 0x01 = sub; funct[0] then selects the operation.
    assign w_funct_ok = (w_funct[5:1] == 5'd0);

`ifdef FPU_DOUBLE_FMT_EN
    logic w_is_dbl;
    // A double occupies an even/odd pair, so the destination must be even.
    assign w_is_dbl = (w_fmt == 5'h11) && !w_fd[0] && w_funct_ok;
    assign w_legal  = ((w_fmt == 5'h10) && w_funct_ok) || w_is_dbl;
`else
    assign w_legal  = (w_fmt == 5'h10) && w_funct_ok;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [31:0]        r_busy;
    logic [31:0]        w_busy_nxt;
    logic [4:0]         r_fd;
    logic [4:0]         w_fd_nxt;
    logic               r_start;
    logic               w_start_nxt;
    logic               r_sub;
    logic               w_sub_nxt;
    logic               r_fwb_en;
    logic               w_fwb_en_nxt;
    logic [4:0]         r_fwb_addr;
    logic [4:0]         w_fwb_addr_nxt;
    logic               r_illegal;
`ifdef FPU_DOUBLE_FMT_EN
    logic               r_dbl;
    logic               w_dbl_nxt;
`endif

    // Hazards: a busy controller blocks every FR op (legal or not); RAW on
    // fs/ft blocks FR ops; a load/store must wait for its ft register.
    assign w_stall = (w_is_fr && ((r_state != S_IDLE) || r_busy[w_fs] || r_busy[w_ft]))
                   || (w_is_mem && r_busy[w_ft]);

    assign w_accept  = w_is_fr &&  w_legal && (r_state == S_IDLE) && !w_stall;
    assign w_illegal = w_is_fr && !w_legal && (r_state == S_IDLE) && !w_stall;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_busy_nxt     = r_busy;
        w_fd_nxt       = r_fd;
        w_start_nxt    = 1'b0;
        w_sub_nxt      = r_sub;
        w_fwb_en_nxt   = 1'b0;
        w_fwb_addr_nxt = r_fwb_addr;
`ifdef FPU_DOUBLE_FMT_EN
        w_dbl_nxt      = r_dbl;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt       = S_EXEC;
                    w_start_nxt       = 1'b1;
                    w_sub_nxt         = w_funct[0];
                    w_fd_nxt          = w_fd;
                    w_cnt_nxt         = c_LOAD_SGL;
                    w_busy_nxt[w_fd]  = 1'b1;
`ifdef FPU_DOUBLE_FMT_EN
                    w_dbl_nxt         = w_is_dbl;
                    if (w_is_dbl) begin
                        w_cnt_nxt                  = c_LOAD_DBL;
                        w_busy_nxt[{w_fd[4:1], 1'b1}] = 1'b1;
                    end
`endif
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    // fwb_en is registered, so it is raised on entry to WB.
                    w_state_nxt    = S_WB;
                    w_fwb_en_nxt   = 1'b1;
                    w_fwb_addr_nxt = r_fd;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            S_WB: begin
                w_busy_nxt[r_fd] = 1'b0;
                w_state_nxt      = S_IDLE;
`ifdef FPU_DOUBLE_FMT_EN
                if (r_dbl) begin
                    w_state_nxt    = S_WB2;
                    w_fwb_en_nxt   = 1'b1;
                    w_fwb_addr_nxt = {r_fd[4:1], 1'b1};
                end
`endif
            end
`ifdef FPU_DOUBLE_FMT_EN
            S_WB2: begin
                w_busy_nxt[{r_fd[4:1], 1'b1}] = 1'b0;
                w_state_nxt                   = S_IDLE;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_busy     <= '0;
            r_fd       <= '0;
            r_start    <= 1'b0;
            r_sub      <= 1'b0;
            r_fwb_en   <= 1'b0;
            r_fwb_addr <= '0;
            r_illegal  <= 1'b0;
`ifdef FPU_DOUBLE_FMT_EN
            r_dbl      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_fd       <= w_fd_nxt;
            r_start    <= w_start_nxt;
            r_sub      <= w_sub_nxt;
            r_fwb_en   <= w_fwb_en_nxt;
            r_fwb_addr <= w_fwb_addr_nxt;
            r_illegal  <= w_illegal;
`ifdef FPU_DOUBLE_FMT_EN
            r_dbl      <= w_dbl_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall     = w_stall;
    assign bus.fpu_start = r_start;
    assign bus.fpu_sub   = r_sub;
    assign bus.fwb_en    = r_fwb_en;
    assign bus.fwb_addr  = r_fwb_addr;
    assign bus.busy_mask = r_busy;
    assign bus.illegal   = r_illegal;
`ifdef FPU_DOUBLE_FMT_EN
    assign bus.fpu_dbl   = r_dbl;
`else
    assign bus.fpu_dbl   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
// ============================================================================
// Module      : tb_fpu_issue_ctrl
// Description : Self-checking bench for fpu_issue_ctrl. A cycle-indexed
//               reference model records, per register, the cycle an op was
//               accepted and the cycle its writeback is due; all expected
//               outputs are derived from those timestamps.
// Options     : FPU_DOUBLE_FMT_EN - also exercises double-format ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_issue_ctrl;

    localparam int c_L = 3;
    localparam int c_E = 2;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fpu_issue_ctrl_if u_if ();

    fpu_issue_ctrl #(
        .FPU_LAT   (c_L),
        .DBL_EXTRA (c_E)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   start_c  = -1;
    int   ill_c    = -1;
    int   last_wb  = -1;
    logic e_sub    = 1'b0;
    logic e_dbl    = 1'b0;
    int   acc_c [32];
    int   wb_c  [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            acc_c[i] = -1;
            wb_c[i]  = -1;
        end
        start_c = -1;
        ill_c   = -1;
        last_wb = -1;
    endtask

    // Register n is busy from the cycle after acceptance through its WB cycle.
    function automatic bit m_busy(input int n);
        return (acc_c[n] < cyc) && (cyc <= wb_c[n]);
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) m[i] = m_busy(i);
        return m;
    endfunction

    function automatic bit m_idle();
        return cyc > last_wb;
    endfunction

    function automatic bit m_legal(input logic [31:0] ins);
        bit f;
        f = (ins[5:0] == 6'h00) || (ins[5:0] == 6'h01);
        if (ins[25:21] == 5'h10) return f;
`ifdef FPU_DOUBLE_FMT_EN
        if ((ins[25:21] == 5'h11) && !ins[6]) return f;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] enc_fr(input logic [4:0] fmt, input logic [4:0] fd,
                                           input logic [4:0] fs, input logic [4:0] ft,
                                           input logic [5:0] funct);
        return {6'h11, fmt, ft, fs, fd, funct};
    endfunction

    function automatic logic [31:0] enc_mem(input logic [5:0] op, input logic [4:0] ft);
        return {op, 5'd1, ft, 16'h0010};
    endfunction

    // One clock cycle: drive inputs, check every output mid-cycle against the
    // model, then advance the model with this cycle's inputs.
    task automatic step(input bit v, input logic [31:0] ins, input bit r);
        bit fr;
        bit mem;
        bit st;
        int fd;
        int fs;
        int ft;
        int n;
        u_if.instr_valid = v;
        u_if.instr       = ins;
        reset            = r;
        #4;
        fr  = v && (ins[31:26] == 6'h11);
        mem = v && ((ins[31:26] == 6'h31) || (ins[31:26] == 6'h39));
        ft  = int'(ins[20:16]);
        fs  = int'(ins[15:11]);
        fd  = int'(ins[10:6]);
        st  = (fr && (!m_idle() || m_busy(fs) || m_busy(ft))) || (mem && m_busy(ft));

        chk("stall",     32'(u_if.stall),     32'(st));
        chk("fpu_start", 32'(u_if.fpu_start), 32'(start_c == cyc));
        if (start_c == cyc) begin
            chk("fpu_sub", 32'(u_if.fpu_sub), 32'(e_sub));
            chk("fpu_dbl", 32'(u_if.fpu_dbl), 32'(e_dbl));
        end
        chk("illegal", 32'(u_if.illegal), 32'(ill_c == cyc));
        n = -1;
        for (int i = 0; i < 32; i++) if (wb_c[i] == cyc) n = i;
        chk("fwb_en", 32'(u_if.fwb_en), 32'(n >= 0));
        if (n >= 0) chk("fwb_addr", 32'(u_if.fwb_addr), 32'(n));
        chk("busy_mask", u_if.busy_mask, m_mask());

        if (r) begin
            model_clear();
        end else if (fr && m_idle() && !st) begin
            if (m_legal(ins)) begin
                start_c   = cyc + 1;
                e_sub     = ins[0];
                e_dbl     = 1'b0;
                acc_c[fd] = cyc;
                wb_c[fd]  = cyc + c_L + 1;
                last_wb   = wb_c[fd];
`ifdef FPU_DOUBLE_FMT_EN
                if (ins[25:21] == 5'h11) begin
                    e_dbl         = 1'b1;
                    wb_c[fd]      = cyc + c_L + c_E + 1;
                    acc_c[fd + 1] = cyc;
                    wb_c[fd + 1]  = cyc + c_L + c_E + 2;
                    last_wb       = wb_c[fd + 1];
                end
`endif
            end else begin
                ill_c = cyc + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    logic [31:0] ins;
    int          sel;
    bit          v;
    bit          r;

    initial begin
        reset            = 1'b1;
        u_if.instr_valid = 1'b0;
        u_if.instr       = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #4;
        // Reset values of the held qualifiers and write address.
        chk("rst_fpu_sub",  32'(u_if.fpu_sub),  32'd0);
        chk("rst_fpu_dbl",  32'(u_if.fpu_dbl),  32'd0);
        chk("rst_fwb_addr", 32'(u_if.fwb_addr), 32'd0);
        @(posedge clk);
        #1;
        cyc = 0;
        step(1'b0, 32'h0, 1'b0);

        // add.s fd=5 fs=1 ft=2, then let it retire.
        step(1'b1, enc_fr(5'h10, 5'd5, 5'd1, 5'd2, 6'h00), 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b0);

        // sub.s fd=3, then another sub.s held while stalled.
        step(1'b1, enc_fr(5'h10, 5'd3, 5'd1, 5'd2, 6'h01), 1'b0);
        step(1'b0, 32'h0, 1'b0);
        repeat (4) step(1'b1, enc_fr(5'h10, 5'd9, 5'd10, 5'd11, 6'h01), 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b0);

        // add.s fd=7, lwc1 ft=7 hazards, lwc1 ft=8 does not.
        step(1'b1, enc_fr(5'h10, 5'd7, 5'd1, 5'd2, 6'h00), 1'b0);
        step(1'b1, enc_mem(6'h31, 5'd8), 1'b0);
        repeat (5) step(1'b1, enc_mem(6'h31, 5'd7), 1'b0);
        step(1'b1, enc_mem(6'h39, 5'd7), 1'b0);

        // Unsupported funct, then unsupported fmt.
        step(1'b1, enc_fr(5'h10, 5'd4, 5'd1, 5'd2, 6'h02), 1'b0);
        step(1'b1, enc_fr(5'h11, 5'd5, 5'd1, 5'd2, 6'h00), 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);

        // Reset abandons an in-flight add.s; fd=0 used as a plain register.
        step(1'b1, enc_fr(5'h10, 5'd0, 5'd1, 5'd2, 6'h00), 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        repeat (10) step(1'b0, 32'h0, 1'b0);

        // add.d fd=4 (issue when enabled, illegal otherwise), then fd=5.
        step(1'b1, enc_fr(5'h11, 5'd4, 5'd1, 5'd2, 6'h00), 1'b0);
        repeat (8) step(1'b0, 32'h0, 1'b0);
        step(1'b1, enc_fr(5'h11, 5'd5, 5'd1, 5'd2, 6'h00), 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b0);

        // Randomised traffic over a small register window to provoke hazards.
        for (int k = 0; k < 1500; k++) begin
            sel = int'($urandom_range(0, 9));
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 79) == 0);
            case (sel)
                0, 1, 2, 3: ins = enc_fr(5'h10, 5'($urandom_range(0, 7)),
                                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                         6'($urandom_range(0, 1)));
                4:          ins = enc_fr(5'($urandom_range(15, 18)), 5'($urandom_range(0, 7)),
                                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                         6'($urandom_range(0, 3)));
                5:          ins = enc_fr(5'h11, 5'($urandom_range(0, 7)),
                                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                         6'($urandom_range(0, 1)));
                6, 7:       ins = enc_mem(($urandom_range(0, 1) != 0) ? 6'h31 : 6'h39,
                                          5'($urandom_range(0, 7)));
                8:          ins = {6'($urandom_range(0, 16)), 26'($urandom)};
                default:    ins = $urandom;
            endcase
            step(v, ins, r);
        end
        repeat (12) step(1'b0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
